// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, the
// multi-cycle FSM states and the bit positions inside the control bundle.
package exe_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REMU = 4'd12
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Positions inside the {memwrite, memtoreg, regwrite} control bundle.
    localparam int CON_REGWRITE = 0;
    localparam int CON_MEMTOREG = 1;
    localparam int CON_MEMWRITE = 2;

    // True for the operations that run on the iterative multiply/divide unit.
    function automatic logic is_multi_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / divide datapath: one shift-add or one
// restoring-division step per enabled cycle. result_o exposes the value that
// the current step produces, so the caller can capture it on the final step.
module muldiv_iter
    import exe_pkg::*;
#(
    parameter int BW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [3:0]    op_i,
    input  logic [BW-1:0] a_i,
    input  logic [BW-1:0] b_i,
    output logic [BW-1:0] result_o
);

    // r: product accumulator (MUL) or partial remainder (DIV)
    // x: shifted multiplicand (MUL) or dividend shifting into quotient (DIV)
    // y: shifted multiplier (MUL) or divisor (DIV)
    logic [BW-1:0] r_q, r_d;
    logic [BW-1:0] x_q, x_d;
    logic [BW-1:0] y_q, y_d;
    logic          is_mul_q;
    logic          want_rem_q;

    logic [BW:0]   trial;
    logic          fits;

    assign trial = {r_q, x_q[BW-1]};
    assign fits  = (trial >= {1'b0, y_q});

    // One algorithm step from the current register values.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        r_d = r_q;
        x_d = x_q;
        y_d = y_q;
        if (is_mul_q) begin
            r_d = y_q[0] ? (r_q + x_q) : r_q;
            x_d = x_q << 1;
            y_d = y_q >> 1;
        end else begin
            // A zero divisor always "fits": quotient becomes all ones and the
            // remainder ends up as the dividend, with no special casing.
            r_d = fits ? (trial[BW-1:0] - y_q) : trial[BW-1:0];
            x_d = {x_q[BW-2:0], fits};
        end
        result_o = (is_mul_q || want_rem_q) ? r_d : x_d;
    end

    // Operand latch on load, one step per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            is_mul_q   <= 1'b0;
            want_rem_q <= 1'b0;
        end else if (load_i) begin
            r_q        <= '0;
            x_q        <= a_i;
            y_q        <= b_i;
            is_mul_q   <= (op_i == OP_MUL);
            want_rem_q <= (op_i == OP_REMU);
        end else if (step_i) begin
            r_q <= r_d;
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: single-cycle ALU for ops 0-9, an IDLE/BUSY FSM that
// drives the iterative multiply/divide unit for ops 10-12, and the registered
// output bundle handed to the memory stage.
module execute_stage
    import exe_pkg::*;
#(
    parameter int BW = 32,
    parameter int OW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          valid_in,
    input  logic [BW-1:0] A_in,
    input  logic [BW-1:0] B_in,
    input  logic [BW-1:0] Imm_in,
    input  logic          ALUSrc,
    input  logic [3:0]    ALUOp,
    input  logic [2:0]    con_in,
    input  logic [4:0]    rd_in,
    output logic          stall_out,
    output logic          valid_out,
    output logic [BW-1:0] Result_out,
    output logic [OW-1:0] Address_out,
    output logic [BW-1:0] WriteData_out,
    output logic [2:0]    con_out,
    output logic [4:0]    rd_out
);

    localparam int CW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BW - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Control captured when a multi-cycle op is accepted.
    logic [2:0]    lat_con_q, lat_con_d;
    logic [4:0]    lat_rd_q, lat_rd_d;
    logic [BW-1:0] lat_wd_q, lat_wd_d;

    logic          valid_d;
    logic [BW-1:0] result_d;
    logic [BW-1:0] wdata_d;
    logic [2:0]    con_d;
    logic [4:0]    rd_d;

    logic [BW-1:0] op2;
    logic [4:0]    shamt;
    logic [BW-1:0] alu_res;
    logic [BW-1:0] md_res;
    logic          accept;
    logic          step;

    assign op2   = ALUSrc ? Imm_in : B_in;
    assign shamt = op2[4:0];

    // Single-cycle ALU; multi-cycle and unused codes yield zero here.
    always_comb begin
        alu_res = '0;
        case (ALUOp)
            OP_ADD:  alu_res = A_in + op2;
            OP_SUB:  alu_res = A_in - op2;
            OP_AND:  alu_res = A_in & op2;
            OP_OR:   alu_res = A_in | op2;
            OP_XOR:  alu_res = A_in ^ op2;
            OP_SLL:  alu_res = A_in << shamt;
            OP_SRL:  alu_res = A_in >> shamt;
            OP_SRA:  alu_res = $signed(A_in) >>> shamt;
            OP_SLT:  alu_res = {{(BW-1){1'b0}}, ($signed(A_in) < $signed(op2))};
            OP_SLTU: alu_res = {{(BW-1){1'b0}}, (A_in < op2)};
            default: alu_res = '0;
        endcase
    end

    muldiv_iter #(.BW(BW)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .step_i   (step),
        .op_i     (ALUOp),
        .a_i      (A_in),
        .b_i      (op2),
        .result_o (md_res)
    );

    // Next state of the FSM and of the output bundle; bubble unless something completes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_con_d = lat_con_q;
        lat_rd_d  = lat_rd_q;
        lat_wd_d  = lat_wd_q;
        valid_d   = 1'b0;
        result_d  = '0;
        wdata_d   = '0;
        con_d     = 3'b000;
        rd_d      = 5'd0;
        accept    = 1'b0;
        step      = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (is_multi_op(ALUOp)) begin
                            accept    = 1'b1;
                            state_d   = ST_BUSY;
                            cnt_d     = '0;
                            lat_con_d = con_in;
                            lat_rd_d  = rd_in;
                            lat_wd_d  = B_in;
                        end else begin
                            valid_d  = 1'b1;
                            result_d = alu_res;
                            wdata_d  = B_in;
                            con_d    = con_in;
                            rd_d     = rd_in;
                        end
                    end
                end
                ST_BUSY: begin
                    step = 1'b1;
                    if (cnt_q == LAST) begin
                        valid_d  = 1'b1;
                        result_d = md_res;
                        wdata_d  = lat_wd_q;
                        con_d    = lat_con_q;
                        rd_d     = lat_rd_q;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state, latched control and the registered output bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            lat_con_q     <= 3'b000;
            lat_rd_q      <= 5'd0;
            lat_wd_q      <= '0;
            valid_out     <= 1'b0;
            Result_out    <= '0;
            Address_out   <= '0;
            WriteData_out <= '0;
            con_out       <= 3'b000;
            rd_out        <= 5'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lat_con_q     <= lat_con_d;
            lat_rd_q      <= lat_rd_d;
            lat_wd_q      <= lat_wd_d;
            valid_out     <= valid_d;
            Result_out    <= result_d;
            Address_out   <= result_d[OW-1:0];
            WriteData_out <= wdata_d;
            con_out       <= con_d;
            rd_out        <= rd_d;
        end
    end

    // Hold upstream while an op is being accepted or is still iterating;
    // the final BUSY cycle releases it so the next instruction can advance.
    assign stall_out = !rst && !flush &&
                       (((state_q == ST_IDLE) && valid_in && is_multi_op(ALUOp)) ||
                        ((state_q == ST_BUSY) && (cnt_q != LAST)));

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter BW, default 32: datapath width.
REQ-002 SHALL have parameter OW, default 10: memory address width delivered downstream.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1: synchronous kill of the in-flight instruction.
REQ-006 SHALL have port valid_in  input  1: an instruction is present on the inputs.
REQ-007 SHALL have ports A_in, B_in, Imm_in  input  BW each: rs1 value, rs2 value, immediate.
REQ-008 SHALL have port ALUSrc  input  1: second operand is Imm_in when 1, else B_in.
REQ-009 SHALL have port ALUOp  input  4: operation select.
REQ-010 SHALL have port con_in  input  3: {memwrite, memtoreg, regwrite}.
REQ-011 SHALL have port rd_in  input  5: destination register.
REQ-012 SHALL have port stall_out  output  1: upstream holds its outputs while high.
REQ-013 SHALL have port valid_out  output  1: registered output holds a real instruction.
REQ-014 SHALL have port Result_out  output  BW: registered operation result.
REQ-015 SHALL have port Address_out  output  OW: Result_out[OW-1:0], registered.
REQ-016 SHALL have port WriteData_out  output  BW: registered B_in (store data, never Imm_in).
REQ-017 SHALL have ports con_out  output  3 and rd_out  output  5: registered control and destination.

Function
REQ-018 SHALL decode ALUOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL, 11 DIVU, 12 REMU; 13-15 give result 0.
REQ-019 SHALL use op2[4:0] as shift amount; ADD/SUB wrap modulo 2^BW; SLT/SLTU give 1 or 0 zero-extended.
REQ-020 SHALL treat ops 0-9 as single-cycle: outputs register one edge after acceptance; stall_out stays low.
REQ-021 SHALL treat ops 10-12 as multi-cycle, run by an FSM with states IDLE and BUSY plus a counter 0..BW-1.
REQ-022 SHALL latch operands and control in IDLE when valid_in is 1 and op is 10-12, move to BUSY, and clear the counter.
REQ-023 SHALL drive stall_out = (IDLE & valid_in & multi-cycle op) | (BUSY & counter != BW-1).
REQ-024 SHALL perform one shift-add (MUL) or one restoring step (DIVU/REMU) per BUSY cycle.
REQ-025 SHALL, on the edge with BUSY & counter == BW-1, load the result and latched control into the output registers, set valid_out to 1, and return to IDLE.
REQ-026 SHALL register a bubble (valid_out 0, con_out 000, others 0) on every edge where no instruction completes, including the acceptance edge and BUSY edges.
REQ-027 SHALL give MUL the low BW bits of the unsigned product.
REQ-028 SHALL, when the divisor is 0, give DIVU all ones and REMU the dividend, using the same BW-cycle latency.
REQ-029 SHALL register a bubble when valid_in is 0, regardless of ALUOp and con_in.
REQ-030 SHALL give flush priority over all else: register a bubble, force the FSM to IDLE, clear the counter, and hold stall_out low in that cycle.
REQ-031 SHALL ignore inputs in BUSY except flush.

Reset
REQ-032 SHALL, while rst is high, clear all output registers to 0, put the FSM in IDLE, clear the counter and latched operands, and drive stall_out 0.
REQ-033 SHALL abort any multi-cycle op on reset; no result from the aborted op appears after reset release.

Structure
REQ-034 SHALL place ALUOp encodings, the FSM state enum and the con bit positions in shared package exe_pkg.
REQ-035 SHALL implement the iterative multiply/divide datapath in one sub-module, muldiv_iter; ALU, FSM and output register stay in execute_stage.

Verification
REQ-036 SHALL verify ADD: A=5, B=7, ALUSrc=0, con_in=001, rd=3 -> next edge Result_out=12, Address_out=12, valid_out=1, con_out=001, rd_out=3.
REQ-037 SHALL verify SW-type ADD: A=0x100, Imm=0x3FC, ALUSrc=1, B=0xDEADBEEF, con_in=100 -> Result_out=0x4FC, Address_out=0x0FC, WriteData_out=0xDEADBEEF.
REQ-038 SHALL verify MUL: A=0x10000, B=0x10001 -> stall_out high exactly 32 cycles, then Result_out=0x00010000 with valid_out=1 and bubbles before it.
REQ-039 SHALL verify DIVU: A=100, B=0 -> Result_out=0xFFFFFFFF; REMU A=100, B=7 -> Result_out=2; both at 32-cycle latency.
REQ-040 SHALL verify flush and reset at BUSY counter 10 -> stall_out low, next output is a bubble, and no late result appears; a following ADD completes in one cycle.
